aes_round_mix: RTL and testbench
================================

Name: aes_round_mix

Overview:
- Back half of an AES round; sits directly downstream of the registered SubBytes stage.
- Consumes the substituted 128-bit state and applies ShiftRows, MixColumns and AddRoundKey in forward or inverse order.
- Uses a 2-stage valid/ready pipeline with full back-pressure. Output feeds the next round's SubBytes input or the cipher output register.

Parameters:
- TAG_W, 4, width of opaque sideband tag (e.g. round index) carried alongside the state.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  stage accepts input this cycle
- mode  in  1  0 = encrypt round, 1 = decrypt round; sampled with in_valid
- last  in  1  1 = final round, skip (Inv)MixColumns; sampled with in_valid
- state_in  in  128  SubBytes output; byte k at [127-8k -: 8], k = row + 4*col
- round_key  in  128  round key, same byte order; sampled with in_valid
- tag_in  in  TAG_W  sideband passed through unchanged
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output
- state_out  out  128  round result
- tag_out  out  TAG_W  tag aligned with state_out

Behaviour:
- Reset: all pipeline registers, state_out, and tag_out are 0. Both stage valid flags and out_valid are 0. in_ready is 1 once rst_n deasserts.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage A (register):
  - ShiftRows (mode 0): out[r+4c] = in[r+4((c+r) mod 4)].
  - InvShiftRows (mode 1): out[r+4c] = in[r+4((c-r) mod 4)].
  - mode, last, round_key and tag are registered with the shifted state.
- Stage B (register):
  - mode 0: MixColumns(A) xor key when last = 0; A xor key when last = 1.
  - mode 1: InvMixColumns(A xor key) when last = 0; A xor key when last = 1.
- MixColumns/InvMixColumns are per column over GF(2^8), polynomial 0x11B.
  - Forward matrix rows: [02 03 01 01] rotated.
  - Inverse matrix rows: [0e 0b 0d 09] rotated.
  - Purely combinational xtime chains; no lookup tables.
- Latency: exactly 2 cycles from input transfer to out_valid when not stalled. Throughput is 1 beat per cycle.
- Stage advance rules:
  - Stage B loads when B is empty or out_ready = 1.
  - Stage A loads when A is empty or A advances into B in the same cycle.
  - in_ready = !A_valid || (!B_valid || out_ready). in_ready is combinational from out_ready; this path is accepted.
- Back-pressure: with out_ready = 0, at most 2 beats are held. Held data and the tag must not change while out_valid && !out_ready.
- Simultaneous events: when B drains and A advances in the same cycle while a new input is accepted, no bubble is inserted and no beat is lost.
- Beat isolation: mode and last are per-beat. Mixed encrypt/decrypt beats in flight are each processed with their own sampled mode and last.
- Reset mid-operation: in-flight beats are discarded asynchronously, all valids clear, no partial output is emitted.
- Inputs while in_ready = 0 are ignored; the upstream holds them.

Test Plan:
- ShiftRows pattern: mode 0, last 1, key 0, state_in 000102…0f -> state_out 00050a0f04090e03080d02070c01060b, tag preserved, out_valid exactly 2 cycles after accept.
- InvShiftRows pattern: mode 1, last 1, key 0, state_in 000102…0f -> state_out 000d0a0704010e0b080502 0f0c090603 (bytes 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03).
- FIPS-197 round 1: mode 0, last 0, state_in d42711aee0bf98f1b8b45de51e415230, key a0fafe1788542cb123a339392a6c7605 -> state_out a49c7ff2689f352b6b5bea43026a5049.
- Inverse round trip: feed the encrypt output above back through mode 1 with the same key and last 0, after applying a reference InvShiftRows/ShiftRows model -> the original pre-MixColumns state is recovered. Also a single-column case: column db135345 with key 0 gives 8e4da1bc (mode 0), and 8e4da1bc gives db135345 (mode 1), using the ShiftRows-neutral pattern.
- Back-pressure: stream 8 beats with distinct tags 0..7 while out_ready toggles randomly, including 5-cycle low stretches -> all 8 beats arrive in order, no duplicates, outputs stable while stalled, in_ready low only when both stages are full.
- Reset mid-flight: 2 beats in pipeline, pulse rst_n low asynchronously between clock edges -> out_valid drops immediately, state_out = 0; after release the next accepted beat emerges correctly in 2 cycles.

Source files
------------

// File: rtl/aes_round_mix.sv
// Back half of an AES round: (Inv)ShiftRows, then (Inv)MixColumns and AddRoundKey.
// Two-stage valid/ready pipeline with full back-pressure. Mode and last travel with each beat.
module aes_round_mix #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic             last,
  input  logic [127:0]     state_in,
  input  logic [127:0]     round_key,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     state_out,
  output logic [TAG_W-1:0] tag_out
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k = row + 4*col sits at [127-8k -: 8]; inverse rotates each row the other way.
  function automatic logic [127:0] shiftRows(input logic [127:0] s, input logic inv);
    logic [127:0] res;
    int src;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        res[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [31:0] mixCol(input logic [31:0] col, input logic inv);
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31-8*i -: 8];
      m2[i]  = xtime(a[i]);
      m4[i]  = xtime(m2[i]);
      m8[i]  = xtime(m4[i]);
      m3[i]  = m2[i] ^ a[i];
      m9[i]  = m8[i] ^ a[i];
      m11[i] = m8[i] ^ m2[i] ^ a[i];
      m13[i] = m8[i] ^ m4[i] ^ a[i];
      m14[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    for (int i = 0; i < 4; i++) begin
      if (inv) begin
        res[31-8*i -: 8] = m14[i] ^ m11[(i+1)%4] ^ m13[(i+2)%4] ^ m9[(i+3)%4];
      end else begin
        res[31-8*i -: 8] = m2[i] ^ m3[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s, input logic inv);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      res[127-32*c -: 32] = mixCol(s[127-32*c -: 32], inv);
    end
    return res;
  endfunction

  logic             aValid_q, aValid_d;
  logic [127:0]     aState_q, aState_d;
  logic [127:0]     aKey_q, aKey_d;
  logic             aMode_q, aMode_d;
  logic             aLast_q, aLast_d;
  logic [TAG_W-1:0] aTag_q, aTag_d;
  logic             bValid_q, bValid_d;
  logic [127:0]     bState_q, bState_d;
  logic [TAG_W-1:0] bTag_q, bTag_d;

  logic         bLoad;
  logic         aLoad;
  logic [127:0] keyed;
  logic [127:0] roundResult;

  assign bLoad    = !bValid_q || out_ready;
  assign aLoad    = !aValid_q || bLoad;
  assign in_ready = aLoad;

  // Decrypt adds the key before InvMixColumns; encrypt adds it after MixColumns.
  always_comb begin
    keyed = aState_q ^ aKey_q;
    roundResult = keyed;
    if (!aLast_q) begin
      if (aMode_q) begin
        roundResult = mixColumns(keyed, 1'b1);
      end else begin
        roundResult = mixColumns(aState_q, 1'b0) ^ aKey_q;
      end
    end
  end

  always_comb begin
    aValid_d = aValid_q;
    aState_d = aState_q;
    aKey_d   = aKey_q;
    aMode_d  = aMode_q;
    aLast_d  = aLast_q;
    aTag_d   = aTag_q;
    bValid_d = bValid_q;
    bState_d = bState_q;
    bTag_d   = bTag_q;
    if (bLoad) begin
      bValid_d = aValid_q;
      if (aValid_q) begin
        bState_d = roundResult;
        bTag_d   = aTag_q;
      end
    end
    if (aLoad) begin
      aValid_d = in_valid;
      if (in_valid) begin
        aState_d = shiftRows(state_in, mode);
        aKey_d   = round_key;
        aMode_d  = mode;
        aLast_d  = last;
        aTag_d   = tag_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aValid_q <= 1'b0;
      aState_q <= '0;
      aKey_q   <= '0;
      aMode_q  <= 1'b0;
      aLast_q  <= 1'b0;
      aTag_q   <= '0;
      bValid_q <= 1'b0;
      bState_q <= '0;
      bTag_q   <= '0;
    end else begin
      aValid_q <= aValid_d;
      aState_q <= aState_d;
      aKey_q   <= aKey_d;
      aMode_q  <= aMode_d;
      aLast_q  <= aLast_d;
      aTag_q   <= aTag_d;
      bValid_q <= bValid_d;
      bState_q <= bState_d;
      bTag_q   <= bTag_d;
    end
  end

  assign out_valid = bValid_q;
  assign state_out = bState_q;
  assign tag_out   = bTag_q;

endmodule

// File: tb/tb_aes_round_mix.sv
// Scoreboard bench for aes_round_mix: known AES vectors, back-pressure streaming and mid-flight reset.
module tb_aes_round_mix;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic         last;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic [3:0]   tag_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic [3:0]   tag_out;

  aes_round_mix #(.TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .last      (last),
    .state_in  (state_in),
    .round_key (round_key),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .tag_out   (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic         mode;
    logic         last;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic [127:0] state;
    logic [3:0]   tag;
    int           cyc;
  } sb_t;

  localparam int NV = 7;
  vec_t vecs [NV];
  sb_t  sbQ [$];

  int           nCompared   = 0;
  int           nMismatched = 0;
  int           cycleNow    = 0;
  logic         prevHold    = 1'b0;
  logic [127:0] prevState   = '0;
  logic [3:0]   prevTag     = '0;

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Forward ShiftRows reference, used to build the decrypt round-trip input.
  function automatic logic [127:0] tbShiftRows(input logic [127:0] s);
    logic [7:0]   b [16];
    logic [127:0] res;
    for (int k = 0; k < 16; k++) b[k] = s[127-8*k -: 8];
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(r+4*c) -: 8] = b[r + 4*((c+r)%4)];
    return res;
  endfunction

  // Called at a negedge; drives one beat per cycle, scoreboards transfers and returns at a negedge.
  task automatic applyStimulus(input int vecFirst, input int count, input logic [3:0] tagBase,
                               input bit stall, input int budget);
    int   sent = 0;
    int   cyc  = 0;
    int   idx;
    sb_t  e;
    while ((sent < count || sbQ.size() != 0) && cyc < budget) begin
      idx = (vecFirst + sent) % NV;
      in_valid  = (sent < count);
      state_in  = vecs[idx].st;
      round_key = vecs[idx].key;
      mode      = vecs[idx].mode;
      last      = vecs[idx].last;
      tag_in    = tagBase + 4'(sent);
      if (stall) out_ready = ((cyc % 12) >= 3 && (cyc % 12) < 8) ? 1'b0 : 1'($urandom_range(0, 1));
      else       out_ready = 1'b1;
      #1;
      if (prevHold) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_state", state_out, prevState);
        checkOutput("hold_tag", tag_out, prevTag);
      end
      if (stall) checkOutput("in_ready", in_ready, !(sbQ.size() == 2 && !out_ready));
      if (out_valid && out_ready) begin
        checkOutput("sb_nonempty", sbQ.size() != 0, 1);
        if (sbQ.size() != 0) begin
          e = sbQ.pop_front();
          checkOutput("state_out", state_out, e.state);
          checkOutput("tag_out", tag_out, e.tag);
          if (!stall) checkOutput("latency", cycleNow - e.cyc, 2);
        end
      end
      if (in_valid && in_ready) begin
        e.state = vecs[idx].exp;
        e.tag   = tag_in;
        e.cyc   = cycleNow;
        sbQ.push_back(e);
        sent++;
      end
      prevHold  = out_valid && !out_ready;
      prevState = state_out;
      prevTag   = tag_out;
      cycleNow++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("all_sent", sent, count);
    checkOutput("drained", sbQ.size(), 0);
  endtask

  initial begin
    logic [127:0] fipsOut;
    fipsOut = 128'ha49c7ff2689f352b6b5bea43026a5049;
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, '0, 1'b0, 1'b1,
                128'h00050a0f04090e03080d02070c01060b};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, '0, 1'b1, 1'b1,
                128'h000d0a0704010e0b0805020f0c090603};
    vecs[2] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605,
                1'b0, 1'b0, fipsOut};
    vecs[3] = '{tbShiftRows(fipsOut), 128'ha0fafe1788542cb123a339392a6c7605, 1'b1, 1'b0,
                128'hd4bf5d30e0b452aeb84111f11e2798e5};
    vecs[4] = '{{4{32'hdb135345}}, '0, 1'b0, 1'b0, {4{32'h8e4da1bc}}};
    vecs[5] = '{{4{32'h8e4da1bc}}, '0, 1'b1, 1'b0, {4{32'hdb135345}}};
    vecs[6] = '{128'h000102030405060708090a0b0c0d0e0f, {16{8'hff}}, 1'b0, 1'b1,
                128'hfffaf5f0fbf6f1fcf7f2fdf8f3fef9f4};

    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; last = 1'b0;
    state_in = '0; round_key = '0; tag_in = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_state_out", state_out, 0);
    checkOutput("rst_tag_out", tag_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    @(negedge clk);

    for (int i = 0; i < NV; i++) applyStimulus(i, 1, 4'(15 - i), 1'b0, 20);
    applyStimulus(0, NV, 4'd9, 1'b0, 100);
    applyStimulus(0, 8, 4'd0, 1'b1, 400);

    // Two beats held with out_ready low, then an asynchronous reset between edges.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; state_in = vecs[2+i].st; round_key = vecs[2+i].key;
      mode = vecs[2+i].mode; last = vecs[2+i].last; tag_in = 4'(3 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checkOutput("full_out_valid", out_valid, 1);
    checkOutput("full_in_ready", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_state_out", state_out, 0);
    checkOutput("midrst_tag_out", tag_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sbQ.delete();
    prevHold = 1'b0;
    @(negedge clk);
    applyStimulus(2, 1, 4'd6, 1'b0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
